instr_fetch: RTL and testbench

//  Fetch/sequencing unit at the address side of the instruction ROM: owns the program

---
 rtl/fetch_pkg.sv | 10 +
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch_pc_next.sv | 23 ++
 rtl/instr_fetch.sv | 83 ++++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit types: run-state encoding traced by the decoder/top for the done/halt handshake.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Decoder/ROM-side bus of the fetch unit; master = fetch unit, slave = decoder/ROM/testbench.
interface instr_fetch_if #(
  parameter int unsigned A  = 10,
  parameter int unsigned W  = 9,
  parameter int unsigned CW = 16
);
  logic          start;
  logic          stall;
  logic          branch_en;
  logic          branch_rel;
  logic [A-1:0]  branch_target;
  logic          halt;
  logic [A-1:0]  instr_address;
  logic [W-1:0]  instr_in;
  logic [W-1:0]  instr_out;
  logic          instr_valid;
  logic [CW-1:0] retired;
  logic          done;

  modport master (
    input  start, stall, branch_en, branch_rel, branch_target, halt, instr_in,
    output instr_address, instr_out, instr_valid, retired, done
  );

  modport slave (
    output start, stall, branch_en, branch_rel, branch_target, halt, instr_in,
    input  instr_address, instr_out, instr_valid, retired, done
  );
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC arithmetic: increment, absolute or PC-relative branch, all modulo 2**A.
module instr_fetch_pc_next #(
  parameter int unsigned A = 10
) (
  input  logic [A-1:0] pc,
  input  logic         branch_en,
  input  logic         branch_rel,
  input  logic [A-1:0] branch_target,
  output logic [A-1:0] next_pc,
  output logic         at_end
);

  // Two's-complement offset added at width A wraps identically in both directions.
  always_comb begin
    next_pc = pc + A'(1);
    if (branch_en) begin
      next_pc = branch_rel ? (pc + branch_target) : branch_target;
    end
  end

  assign at_end = (pc == {A{1'b1}});

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing unit: owns the PC, drives the ROM address, counts retired instructions.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned A        = 10,
  parameter int unsigned W        = 9,
  parameter int unsigned CW       = 16,
  parameter int unsigned START_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam logic [A-1:0]  PC_INIT     = A'(START_PC);
  localparam logic [CW-1:0] RETIRED_MAX = {CW{1'b1}};

  fetch_state_t  state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [CW-1:0] retired_q, retired_d;
  logic [A-1:0]  next_pc;
  logic          at_end;

  instr_fetch_pc_next #(.A(A)) u_pc_next (
    .pc            (pc_q),
    .branch_en     (bus.branch_en),
    .branch_rel    (bus.branch_rel),
    .branch_target (bus.branch_target),
    .next_pc       (next_pc),
    .at_end        (at_end)
  );

  // Sequencing priority on a retiring cycle: halt > branch > end-of-memory > increment.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = RUN;
          pc_d      = PC_INIT;
          retired_d = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          retired_d = (retired_q == RETIRED_MAX) ? retired_q : retired_q + CW'(1);
          if (bus.halt) begin
            state_d = DONE;
          end else if (bus.branch_en) begin
            pc_d = next_pc;
          end else if (at_end) begin
            state_d = DONE;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= PC_INIT;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // ROM word passes straight through to the decoder while running.
  assign bus.instr_address = pc_q;
  assign bus.instr_valid   = (state_q == RUN);
  assign bus.instr_out     = (state_q == RUN) ? bus.instr_in : W'(0);
  assign bus.retired       = retired_q;
  assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: main instance (CW=16, START_PC=0) and a small one (CW=4, START_PC=0x3FE).
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  instr_fetch_if #(.A(10), .W(9), .CW(16)) bus1 ();
  instr_fetch_if #(.A(10), .W(9), .CW(4))  bus2 ();

  instr_fetch #(.A(10), .W(9), .CW(16), .START_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  instr_fetch #(.A(10), .W(9), .CW(4), .START_PC(32'h3FE)) dut_small (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  logic [8:0] rom [1024];

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 7 + 3) & 9'h1FF);
  end

  assign bus1.instr_in = rom[bus1.instr_address];
  assign bus2.instr_in = rom[bus2.instr_address];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus1.start = 0; bus1.stall = 0; bus1.branch_en = 0; bus1.branch_rel = 0;
    bus1.branch_target = '0; bus1.halt = 0;
    bus2.start = 0; bus2.stall = 0; bus2.branch_en = 0; bus2.branch_rel = 0;
    bus2.branch_target = '0; bus2.halt = 0;
  endtask

  task automatic branch1(input logic rel, input logic [9:0] tgt);
    bus1.branch_en = 1; bus1.branch_rel = rel; bus1.branch_target = tgt;
  endtask

  initial begin
    clear_inputs();
    reset = 1; reset2 = 1;
    step(); step();
    reset = 0; reset2 = 0;

    // Reset state
    check("rst_valid", 32'(bus1.instr_valid), 0);
    check("rst_done", 32'(bus1.done), 0);
    check("rst_retired", 32'(bus1.retired), 0);
    check("rst_addr", 32'(bus1.instr_address), 0);
    check("rst_instr_out", 32'(bus1.instr_out), 0);

    // 1: linear run, HALT at word 5
    bus1.start = 1; step(); bus1.start = 0;
    for (int k = 0; k < 6; k++) begin
      bus1.halt = (k == 5);
      check($sformatf("lin_addr%0d", k), 32'(bus1.instr_address), 32'(k));
      check($sformatf("lin_instr%0d", k), 32'(bus1.instr_out), 32'(rom[k]));
      check($sformatf("lin_valid%0d", k), 32'(bus1.instr_valid), 1);
      step();
    end
    bus1.halt = 0;
    check("lin_done", 32'(bus1.done), 1);
    check("lin_valid_off", 32'(bus1.instr_valid), 0);
    check("lin_instr_zero", 32'(bus1.instr_out), 0);
    check("lin_retired", 32'(bus1.retired), 6);
    check("lin_pc_hold", 32'(bus1.instr_address), 5);
    step();
    check("lin_done_level", 32'(bus1.done), 1);

    // 2: branches, restart from DONE
    bus1.start = 1; step(); bus1.start = 0;
    check("br_done_low", 32'(bus1.done), 0);
    check("br_restart_addr", 32'(bus1.instr_address), 0);
    check("br_restart_ret", 32'(bus1.retired), 0);
    step(); step();
    check("br_at2", 32'(bus1.instr_address), 2);
    branch1(0, 10'h040); step();
    check("br_abs", 32'(bus1.instr_address), 32'h040);
    branch1(1, 10'h3FE); step();
    check("br_rel_neg", 32'(bus1.instr_address), 32'h03E);
    branch1(0, 10'h3FF); step();
    check("br_abs_top", 32'(bus1.instr_address), 32'h3FF);
    branch1(1, 10'h003); step();
    check("br_rel_wrap", 32'(bus1.instr_address), 32'h002);
    check("br_retired", 32'(bus1.retired), 6);

    // 3: stall with pending branch
    branch1(0, 10'h007); step();
    check("st_at7", 32'(bus1.instr_address), 7);
    check("st_ret_before", 32'(bus1.retired), 7);
    branch1(0, 10'h100); bus1.stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("st_addr%0d", k), 32'(bus1.instr_address), 7);
      check($sformatf("st_ret%0d", k), 32'(bus1.retired), 7);
    end
    check("st_valid", 32'(bus1.instr_valid), 1);
    bus1.stall = 0; step();
    check("st_released", 32'(bus1.instr_address), 32'h100);
    check("st_ret_after", 32'(bus1.retired), 8);
    bus1.branch_en = 0;
    bus1.halt = 1; bus1.start = 1; step(); bus1.halt = 0; bus1.start = 0;
    check("st_halt_beats_start", 32'(bus1.done), 1);
    check("st_halt_ret", 32'(bus1.retired), 9);
    check("st_halt_pc", 32'(bus1.instr_address), 32'h100);

    // 5: start ignored in RUN, then reset mid-run
    bus1.start = 1; step(); bus1.start = 0;
    bus1.start = 1; branch1(0, 10'h010); step();
    bus1.start = 0; bus1.branch_en = 0;
    check("rr_addr10", 32'(bus1.instr_address), 32'h010);
    check("rr_ret", 32'(bus1.retired), 1);
    check("rr_still_run", 32'(bus1.instr_valid), 1);
    reset = 1; step(); reset = 0;
    check("rr_valid", 32'(bus1.instr_valid), 0);
    check("rr_done", 32'(bus1.done), 0);
    check("rr_pc", 32'(bus1.instr_address), 0);
    check("rr_retired", 32'(bus1.retired), 0);
    check("rr_instr_out", 32'(bus1.instr_out), 0);
    branch1(0, 10'h055); bus1.halt = 1; step();
    clear_inputs();
    check("idle_ignores", 32'(bus1.instr_address), 0);
    check("idle_stays", 32'(bus1.instr_valid), 0);

    // 4: end-of-memory on the small instance (START_PC = 0x3FE)
    bus2.start = 1; step(); bus2.start = 0;
    check("eom_addr0", 32'(bus2.instr_address), 32'h3FE);
    step();
    check("eom_addr1", 32'(bus2.instr_address), 32'h3FF);
    check("eom_not_done", 32'(bus2.done), 0);
    step();
    check("eom_done", 32'(bus2.done), 1);
    check("eom_pc", 32'(bus2.instr_address), 32'h3FF);
    check("eom_retired", 32'(bus2.retired), 2);

    // 6: saturation, tight loop via rel offset 0
    bus2.start = 1; step(); bus2.start = 0;
    bus2.branch_en = 1; bus2.branch_rel = 1; bus2.branch_target = '0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("sat_ret%0d", i), 32'(bus2.retired), (i > 15) ? 15 : i);
      step();
    end
    check("sat_final", 32'(bus2.retired), 15);
    check("sat_loop_pc", 32'(bus2.instr_address), 32'h3FE);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
